// File: rtl/rx_pkg.sv
// Shared constants and types for the serial receive stage.
package rx_pkg;
    localparam int   DATA_W    = 55;
    localparam int   CNT_W     = 6;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA     = 2'd1,
        STOP     = 2'd2,
        ERR_WAIT = 2'd3
    } rx_state_e;
endpackage

// File: rtl/receiver_if.sv
// Output-side port bundle of the receiver.
// The master side is the receiver. The slave side is the consumer.
interface receiver_if;
    import rx_pkg::*;

    logic [DATA_W-1:0] RX_Data;
    logic              RX_Data_Valid;
    logic              RX_Ready;
    logic              RX_Frame_Err;
    logic              RX_Overrun;

    modport master (
        output RX_Data, RX_Data_Valid, RX_Frame_Err, RX_Overrun,
        input  RX_Ready
    );

    modport slave (
        input  RX_Data, RX_Data_Valid, RX_Frame_Err, RX_Overrun,
        output RX_Ready
    );
endinterface

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line.
// On reset, both flops go to the idle level, so reset itself can never
// look like a start bit.
module rx_sync
    import rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // Shift the raw line through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= LINE_IDLE;
            q    <= LINE_IDLE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/receiver.sv
// Serial-to-parallel receive stage.
//
// Frame format: start bit 0, then DATA_W data bits (MSB first), then stop bit 1.
// The line is sampled once per clk, with no oversampling.
// A good frame lands in a one-deep output register that uses a valid/ready handshake.
// A bad stop bit pulses RX_Frame_Err.
// A good frame that arrives while the output register is still full is dropped,
// and RX_Overrun pulses.
//
// Build option RX_SYNC_EN: the line goes through a 2-flop synchronizer first.
// This adds two cycles of latency.
module receiver
    import rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       S_Data,
    receiver_if.master rx
);
    logic line;

`ifdef RX_SYNC_EN
    rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (S_Data),
        .q   (line)
    );
`else
    assign line = S_Data;
`endif

    rx_state_e         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              good;
    logic              ferr;

    // Frame FSM state, bit counter and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    // Next-state logic. good and ferr are single-cycle strobes taken in STOP.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        good      = 1'b0;
        ferr      = 1'b0;
        case (state)
            IDLE: begin
                if (line != LINE_IDLE) begin
                    state_nxt = DATA;
                    cnt_nxt   = CNT_W'(DATA_W - 1);
                end
            end
            DATA: begin
                shreg_nxt = {shreg[DATA_W-2:0], line};
                if (cnt == '0) begin
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (line == LINE_IDLE) begin
                    good      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    ferr      = 1'b1;
                    shreg_nxt = '0;
                    state_nxt = ERR_WAIT;
                end
            end
            ERR_WAIT: begin
                // A line held low after a framing error must not be taken
                // as a fresh start bit.
                if (line == LINE_IDLE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register and status pulses.
    // A completing frame wins over an accept in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx.RX_Data       <= '0;
            rx.RX_Data_Valid <= 1'b0;
            rx.RX_Frame_Err  <= 1'b0;
            rx.RX_Overrun    <= 1'b0;
        end else begin
            rx.RX_Frame_Err <= ferr;
            rx.RX_Overrun   <= good && rx.RX_Data_Valid && !rx.RX_Ready;
            if (good && (!rx.RX_Data_Valid || rx.RX_Ready)) begin
                rx.RX_Data       <= shreg;
                rx.RX_Data_Valid <= 1'b1;
            end else if (rx.RX_Ready) begin
                rx.RX_Data_Valid <= 1'b0;
            end
        end
    end
endmodule
